// File: rtl/adder_checker_if.sv
// ---------------------------------------------------------------------------
// adder_checker_if
// Tap bus between the adder under test and its result checker. It carries the
// operands that drive the adder and the adder's registered result.
//   enable   : adder enable; a disabled adder outputs 0
//   din_x/y  : WL-bit operands
//   dut_out  : adder data_out
// The master modport is the side that drives the adder, and the slave modport
// is the checker, which only observes.
// ---------------------------------------------------------------------------
interface adder_checker_if #(
    parameter int WL = 8
);
    logic          enable;
    logic [WL-1:0] din_x;
    logic [WL-1:0] din_y;
    logic [WL-1:0] dut_out;

    modport master (output enable, output din_x, output din_y, output dut_out);
    modport slave  (input  enable, input  din_x, input  din_y, input  dut_out);
endinterface

// File: rtl/adder_checker.sv
// ---------------------------------------------------------------------------
// adder_checker
// Result monitor for the registered adder. It recomputes the expected sum
// through a golden pipeline matched to the adder latency (LAT). It compares
// that value against the adder output over a window of num_samples_i
// operand cycles, and reports counts plus a capture of the first mismatch.
//
// Ports
//   clk, rst          : clock; asynchronous active-high reset
//   start_i           : opens a window (honoured in IDLE/DONE only)
//   num_samples_i     : window length, latched on the accepted start
//   tap               : operand/result tap bus (slave modport)
//   busy_o            : window in progress (RUN or DRAIN)
//   done_o            : window finished; held until the next accepted start
//   err_flag_o        : sticky mismatch flag for the current window
//   sample_cnt_o      : comparisons completed in the current window
//   err_cnt_o         : mismatches, saturating at all-ones
//   first_exp_o/act_o : expected/actual values at the first mismatch
//   first_idx_o       : 0-based sample index of the first mismatch
//   state_o           : FSM state for debug (0 IDLE, 1 RUN, 2 DRAIN, 3 DONE)
//
// Control handshake: start_i has no ready. It is a single-cycle pulse, and it
// is accepted on any rising edge where the FSM is in IDLE or DONE. Pulses
// that arrive in RUN or DRAIN are dropped.
// ---------------------------------------------------------------------------
module adder_checker #(
    parameter int WL  = 8,
    parameter int LAT = 1,
    parameter int CW  = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [CW-1:0] num_samples_i,
    adder_checker_if.slave tap,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_flag_o,
    output logic [CW-1:0] sample_cnt_o,
    output logic [CW-1:0] err_cnt_o,
    output logic [WL-1:0] first_exp_o,
    output logic [WL-1:0] first_act_o,
    output logic [CW-1:0] first_idx_o,
    output logic [1:0]    state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CW-1:0] ONE = 1;

    state_t        state_q;
    logic [CW-1:0] n_q;
    logic [CW-1:0] issue_cnt_q;
    logic [CW-1:0] sample_cnt_q;
    logic [CW-1:0] err_cnt_q;
    logic [CW-1:0] first_idx_q;
    logic [WL-1:0] first_exp_q;
    logic [WL-1:0] first_act_q;
    logic          err_flag_q;
    logic          busy_q;
    logic          done_q;

    // Golden pipeline: one {tag, exp} pair per stage. Stage 0 loads every edge.
    logic [WL-1:0] exp_pipe_q [LAT];
    logic [LAT-1:0] tag_pipe_q;

    logic [WL-1:0] sum_d;
    logic [WL-1:0] exp_d;
    logic          cmp_valid;
    logic [WL-1:0] cmp_exp;
    logic          mismatch;
    logic [CW-1:0] sample_cnt_d;
    logic [CW-1:0] issue_cnt_d;
    logic          last_cmp;

    always_comb begin
        // The carry is dropped, matching the WL-bit adder result.
        sum_d        = tap.din_x + tap.din_y;
        exp_d        = tap.enable ? sum_d : '0;
        cmp_valid    = tag_pipe_q[LAT-1];
        cmp_exp      = exp_pipe_q[LAT-1];
        mismatch     = cmp_valid && (tap.dut_out != cmp_exp);
        sample_cnt_d = sample_cnt_q + ONE;
        issue_cnt_d  = issue_cnt_q + ONE;
        // This is the final comparison of the window: it brings sample_cnt up to N.
        last_cmp     = cmp_valid && (sample_cnt_d == n_q);
    end

    // Only operand cycles sampled while in RUN carry a tag. The first tagged
    // cycle is therefore the edge after the accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_pipe_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                exp_pipe_q[i] <= '0;
            end
        end else begin
            tag_pipe_q[0] <= (state_q == RUN);
            exp_pipe_q[0] <= exp_d;
            for (int i = 1; i < LAT; i++) begin
                tag_pipe_q[i] <= tag_pipe_q[i-1];
                exp_pipe_q[i] <= exp_pipe_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            n_q          <= '0;
            issue_cnt_q  <= '0;
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            err_flag_q   <= 1'b0;
            first_exp_q  <= '0;
            first_act_q  <= '0;
            first_idx_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            // Comparisons only occur while tags are in flight (RUN/DRAIN). They
            // never coincide with the start branch below, which clears the counters.
            if (cmp_valid) begin
                sample_cnt_q <= sample_cnt_d;
                if (mismatch) begin
                    err_flag_q <= 1'b1;
                    if (err_cnt_q != '1) begin
                        err_cnt_q <= err_cnt_q + ONE;
                    end
                    if (!err_flag_q) begin
                        first_exp_q <= cmp_exp;
                        first_act_q <= tap.dut_out;
                        first_idx_q <= sample_cnt_q;
                    end
                end
            end

            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        n_q          <= num_samples_i;
                        issue_cnt_q  <= '0;
                        sample_cnt_q <= '0;
                        err_cnt_q    <= '0;
                        err_flag_q   <= 1'b0;
                        first_exp_q  <= '0;
                        first_act_q  <= '0;
                        first_idx_q  <= '0;
                        if (num_samples_i == '0) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    issue_cnt_q <= issue_cnt_d;
                    if (issue_cnt_d == n_q) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (last_cmp) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_flag_o   = err_flag_q;
    assign sample_cnt_o = sample_cnt_q;
    assign err_cnt_o    = err_cnt_q;
    assign first_exp_o  = first_exp_q;
    assign first_act_o  = first_act_q;
    assign first_idx_o  = first_idx_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_adder_checker.sv
// ---------------------------------------------------------------------------
// tb_adder_checker
// Directed bench for adder_checker. A behavioural LAT=1 adder drives dut_out.
// Its registered result can be overridden per operand cycle to plant faults.
// Inputs change on the falling edge, and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_adder_checker;
    localparam int WL  = 8;
    localparam int LAT = 1;
    localparam int CW  = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT and tap bus ----------------
    logic          start       = 1'b0;
    logic [CW-1:0] num_samples = '0;
    logic          busy, done, err_flag;
    logic [CW-1:0] sample_cnt, err_cnt, first_idx;
    logic [WL-1:0] first_exp, first_act;
    logic [1:0]    state;

    adder_checker_if #(.WL(WL)) tap_if ();

    // Behavioural registered adder with per-cycle fault override.
    logic          fault_en  = 1'b0;
    logic [WL-1:0] fault_val = '0;
    logic [WL-1:0] adder_q;
    always @(posedge clk)
        adder_q <= fault_en ? fault_val : (tap_if.enable ? WL'(tap_if.din_x + tap_if.din_y) : '0);
    assign tap_if.dut_out = adder_q;

    adder_checker #(.WL(WL), .LAT(LAT), .CW(CW)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start),
        .num_samples_i (num_samples),
        .tap           (tap_if),
        .busy_o        (busy),
        .done_o        (done),
        .err_flag_o    (err_flag),
        .sample_cnt_o  (sample_cnt),
        .err_cnt_o     (err_cnt),
        .first_exp_o   (first_exp),
        .first_act_o   (first_act),
        .first_idx_o   (first_idx),
        .state_o       (state)
    );

    // ---------------- scoreboard ----------------
    int vectors     = 0;
    int miscompares = 0;
    int e0          = 0;
    int lat         = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_busy"},       64'(busy),       64'd0);
        check({pfx, "_done"},       64'(done),       64'd0);
        check({pfx, "_err_flag"},   64'(err_flag),   64'd0);
        check({pfx, "_sample_cnt"}, 64'(sample_cnt), 64'd0);
        check({pfx, "_err_cnt"},    64'(err_cnt),    64'd0);
        check({pfx, "_first_exp"},  64'(first_exp),  64'd0);
        check({pfx, "_first_act"},  64'(first_act),  64'd0);
        check({pfx, "_first_idx"},  64'(first_idx),  64'd0);
        check({pfx, "_state"},      64'(state),      64'd0);
    endtask

    // ---------------- driver tasks ----------------
    // Called at a falling edge. Holds start over one rising edge (E0).
    task automatic start_pulse(input logic [CW-1:0] n);
        start       = 1'b1;
        num_samples = n;
        @(negedge clk);
        start = 1'b0;
        e0    = cyc;
    endtask

    // One operand cycle, sampled by the next rising edge.
    task automatic issue(input logic en, input logic [WL-1:0] x, input logic [WL-1:0] y,
                         input logic fe, input logic [WL-1:0] fv);
        tap_if.enable = en;
        tap_if.din_x  = x;
        tap_if.din_y  = y;
        fault_en      = fe;
        fault_val     = fv;
        @(negedge clk);
    endtask

    task automatic idle_ops();
        tap_if.enable = 1'b0;
        tap_if.din_x  = '0;
        tap_if.din_y  = '0;
        fault_en      = 1'b0;
        fault_val     = '0;
    endtask

    // Bounded wait for done. lat holds rising edges since E0, or -1 on timeout.
    task automatic wait_done(input int budget);
        lat = -1;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                lat = cyc - e0;
                break;
            end
            @(negedge clk);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        idle_ops();

        // Asynchronous reset with no clock edge in between.
        #1 rst = 1'b1;
        #1 check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_state", 64'(state), 64'd0);
        check("post_reset_busy",  64'(busy),  64'd0);

        // Clean run, N=16 random operands.
        start_pulse(16);
        check("clean_busy_after_start", 64'(busy), 64'd1);
        for (int i = 0; i < 16; i++)
            issue(1'b1, WL'($urandom_range(0, 255)), WL'($urandom_range(0, 255)), 1'b0, 8'h00);
        idle_ops();
        wait_done(40);
        check("clean_done_latency", 64'(lat),        64'd17);
        check("clean_sample_cnt",   64'(sample_cnt), 64'd16);
        check("clean_err_cnt",      64'(err_cnt),    64'd0);
        check("clean_err_flag",     64'(err_flag),   64'd0);
        check("clean_busy_low",     64'(busy),       64'd0);
        check("clean_state_done",   64'(state),      64'd3);

        // Fault capture. Samples 2 and 3 are corrupted.
        start_pulse(4);
        check("restart_sample_cnt_clear", 64'(sample_cnt), 64'd0);
        check("restart_done_low",         64'(done),       64'd0);
        issue(1'b1, 8'h10, 8'h20, 1'b0, 8'h00);
        issue(1'b1, 8'h10, 8'h20, 1'b0, 8'h00);
        issue(1'b1, 8'h10, 8'h20, 1'b1, 8'h31);
        issue(1'b1, 8'h10, 8'h20, 1'b1, 8'h00);
        idle_ops();
        wait_done(20);
        check("fault_done_latency", 64'(lat),        64'd5);
        check("fault_err_cnt",      64'(err_cnt),    64'd2);
        check("fault_err_flag",     64'(err_flag),   64'd1);
        check("fault_first_exp",    64'(first_exp),  64'h30);
        check("fault_first_act",    64'(first_act),  64'h31);
        check("fault_first_idx",    64'(first_idx),  64'd2);
        check("fault_sample_cnt",   64'(sample_cnt), 64'd4);

        // Arithmetic edges. The carry wraps, and the disabled case expects 0.
        start_pulse(2);
        issue(1'b1, 8'hFF, 8'h01, 1'b0, 8'h00);
        issue(1'b0, 8'h55, 8'h55, 1'b0, 8'h00);
        idle_ops();
        wait_done(20);
        check("arith_err_cnt",    64'(err_cnt),    64'd0);
        check("arith_err_flag",   64'(err_flag),   64'd0);
        check("arith_sample_cnt", 64'(sample_cnt), 64'd2);

        // Disabled adder reporting the raw sum must be flagged against exp 0.
        start_pulse(1);
        issue(1'b0, 8'h55, 8'h55, 1'b1, 8'hAA);
        idle_ops();
        wait_done(20);
        check("dis_err_cnt",   64'(err_cnt),   64'd1);
        check("dis_first_exp", 64'(first_exp), 64'h00);
        check("dis_first_act", 64'(first_act), 64'hAA);
        check("dis_first_idx", 64'(first_idx), 64'd0);

        // num_samples = 0 goes straight to DONE with cleared counters.
        start_pulse(0);
        check("zero_done",       64'(done),       64'd1);
        check("zero_busy",       64'(busy),       64'd0);
        check("zero_sample_cnt", 64'(sample_cnt), 64'd0);
        check("zero_err_cnt",    64'(err_cnt),    64'd0);
        check("zero_err_flag",   64'(err_flag),   64'd0);
        check("zero_state",      64'(state),      64'd3);

        // A second start mid-RUN is ignored.
        start_pulse(8);
        for (int i = 0; i < 3; i++)
            issue(1'b1, WL'($urandom_range(0, 255)), WL'($urandom_range(0, 255)), 1'b0, 8'h00);
        start       = 1'b1;
        num_samples = 3;
        issue(1'b1, 8'h01, 8'h02, 1'b0, 8'h00);
        start = 1'b0;
        for (int i = 0; i < 4; i++)
            issue(1'b1, WL'($urandom_range(0, 255)), WL'($urandom_range(0, 255)), 1'b0, 8'h00);
        idle_ops();
        wait_done(30);
        check("midstart_done_latency", 64'(lat),        64'd9);
        check("midstart_sample_cnt",   64'(sample_cnt), 64'd8);
        check("midstart_err_cnt",      64'(err_cnt),    64'd0);

        // Reset mid-window after 5 samples with 1 error.
        start_pulse(10);
        issue(1'b1, 8'h01, 8'h02, 1'b0, 8'h00);
        issue(1'b1, 8'h03, 8'h04, 1'b1, 8'h99);
        issue(1'b1, 8'h05, 8'h06, 1'b0, 8'h00);
        issue(1'b1, 8'h07, 8'h08, 1'b0, 8'h00);
        issue(1'b1, 8'h09, 8'h0A, 1'b0, 8'h00);
        @(negedge clk);
        check("midrst_pre_sample_cnt", 64'(sample_cnt), 64'd5);
        check("midrst_pre_err_cnt",    64'(err_cnt),    64'd1);
        check("midrst_pre_state",      64'(state),      64'd1);
        idle_ops();
        #2 rst = 1'b1;
        #1 check_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start_pulse(3);
        issue(1'b1, 8'h80, 8'h80, 1'b0, 8'h00);
        issue(1'b1, 8'h12, 8'h34, 1'b0, 8'h00);
        issue(1'b1, 8'hF0, 8'h0F, 1'b0, 8'h00);
        idle_ops();
        wait_done(20);
        check("after_rst_done_latency", 64'(lat),        64'd4);
        check("after_rst_sample_cnt",   64'(sample_cnt), 64'd3);
        check("after_rst_err_cnt",      64'(err_cnt),    64'd0);
        check("after_rst_err_flag",     64'(err_flag),   64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/adder_checker.md
# adder_checker

Self-checking result monitor that sits directly downstream of the registered adder in the overclocking test platform. It taps the same `enable`/`din_x`/`din_y` operands that drive the adder and recomputes the expected sum through a golden pipeline matched to the adder's latency. It compares the golden value against the adder's `data_out` over a software-defined window of samples and reports the sample count, the error count and a capture of the first mismatch. Timing failures at raised clock rates show up as nonzero `err_cnt`.

## Interface
- `WL`, 8: operand/result width; must match the adder.
- `LAT`, 1: adder latency in cycles, ≥1.
- `CW`, 32: width of the counters and of `num_samples`.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset; clears all state immediately.
- `start`  in  1  single-cycle pulse that opens a test window; honoured only in IDLE or DONE.
- `num_samples`  in  CW  window length; sampled on the accepted `start`.
- `enable`  in  1  same signal that drives the adder's `enable`.
- `din_x`, `din_y`  in  WL  same operands that drive the adder.
- `dut_out`  in  WL  the adder's `data_out`.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  high in DONE; held until the next accepted `start`.
- `err_flag`  out  1  sticky; set on any mismatch, cleared by an accepted `start`.
- `sample_cnt`  out  CW  number of comparisons completed in the current window.
- `err_cnt`  out  CW  number of mismatches; saturates at all-ones.
- `first_exp`, `first_act`  out  WL  expected and actual values at the first mismatch.
- `first_idx`  out  CW  0-based sample index of the first mismatch.

## Operation
- Golden model: `exp = enable ? (din_x + din_y) mod 2^WL : 0`. The carry is discarded. This matches the adder, which outputs 0 when disabled.
- Golden pipeline: `LAT` register stages, each carrying `{tag, exp}`. Stage 1 loads on every edge. `tag` = 1 only for operand cycles issued in RUN. When stage `LAT` holds `tag`=1, that entry is compared against the current `dut_out`.
- FSM states:
  - IDLE: reset state.
  - IDLE/DONE + `start`:
    - Clear `sample_cnt`, `err_cnt`, `err_flag`, `first_*` and the issue counter.
    - Latch `num_samples`.
    - Go to RUN, or go straight to DONE if `num_samples` = 0.
  - RUN: issues one tag per cycle and increments the issue counter. After the cycle that issues tag number N, go to DRAIN.
  - DRAIN: issues no tags. Go to DONE on the edge that performs the final comparison, i.e. when `sample_cnt` becomes N.
  - DONE: outputs are held.
  - `start` in RUN/DRAIN is ignored.
- Each comparison:
  - Increment `sample_cnt`.
  - On mismatch:
    - Increment `err_cnt`, saturating.
    - Set `err_flag`.
    - If `err_flag` was 0 before this edge, load `first_exp`, `first_act` and `first_idx` (`first_idx` = `sample_cnt` value before the increment).
- `rst` asserted at any time, including mid-window, forces IDLE and zeroes every register and pipeline tag asynchronously. No partial results survive.

## Timing
- Reset values: all outputs 0; state IDLE.
- `start` accepted at edge E0. `busy` = 1 from E0. Operands are sampled at edges E1…EN.
- The operand sampled at edge Ek is compared at edge Ek+LAT. Counter and `first_*` updates are visible immediately after that edge.
- `done` rises on edge EN+LAT, the same edge as the last counter update. `busy` falls on that same edge.
- With `num_samples` = 0, `done` = 1 after E0 and `sample_cnt` = 0.
- `err_cnt` saturation: once at 2^CW−1 it stays there. `sample_cnt` never exceeds N.
- Restart from DONE: counters clear on the accepted `start` edge. The previous window's results are lost.

## Test plan
- Reset: assert `rst` asynchronously without a clock edge → all outputs 0 immediately. Release → IDLE, `busy` = 0.
- Clean run: DUT is a behavioural LAT=1 adder, N=16 random operands, `enable`=1 → `done` 17 edges after `start`; `sample_cnt`=16, `err_cnt`=0, `err_flag`=0.
- Fault capture: samples 0..3 with x=0x10, y=0x20. The DUT output for sample 2 is forced to 0x31, and for sample 3 to 0x00 → `err_cnt`=2, `first_exp`=0x30, `first_act`=0x31, `first_idx`=2.
- Arithmetic edges: x=0xFF, y=0x01 → exp 0x00. `enable`=0 with x=0x55, y=0x55 → exp 0x00. The DUT matching in both cases → `err_cnt`=0.
- Control edges: `num_samples`=0 → `done` one edge after `start`, `sample_cnt`=0. A second `start` pulse mid-RUN with N=8 → ignored, final `sample_cnt`=8. `start` in DONE → counters clear and a new window runs.
- Reset mid-window: assert `rst` in RUN after 5 samples with 1 error → all outputs 0 and state IDLE. A new `start` after release runs cleanly.
